// File: rtl/rs_pkg.sv
// Shared types and sizing for the RS-array psum serializer.
package rs_pkg;

    localparam int DATA_W = 16;
    localparam int MAX_P  = 24;
    localparam int CNT_W  = 5;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } ser_state_t;

endpackage

// File: rtl/piso_cell.sv
// One word of the parallel-in/serial-out bank: parallel load has priority over shift.
module piso_cell #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] par_in,
    input  logic [DATA_W-1:0] ser_in,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next value: capture, shift one position toward the output, or hold.
    always_comb begin
        data_d = data_q;
        if (load_en) begin
            data_d = par_in;
        end else if (shift_en) begin
            data_d = ser_in;
        end
    end

    // Word register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/psum_serializer.sv
// Parallel-in/serial-out unloader: captures up to DEPTH words at once and streams
// them highest valid index first over a valid/ready beat interface.
//
// Handshake: a beat transfers on a rising clk edge when out_valid && out_ready.
// Once out_valid is high, it and D_out stay unchanged until that transfer happens.
module psum_serializer #(
    parameter int DATA_W = rs_pkg::DATA_W,
    parameter int DEPTH  = rs_pkg::MAX_P,
    parameter int CNT_W  = rs_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [CNT_W-1:0]        p,
    input  logic [DEPTH*DATA_W-1:0] d_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       D_out,
    output logic                    busy,
    output logic                    done
);

    import rs_pkg::*;

    ser_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] p_eff;
    logic             xfer;
    logic             load_bank;
    logic [DEPTH*DATA_W-1:0] aligned;
    logic [DATA_W-1:0] cell_q [DEPTH];

    // Oversized p clamps to the bank depth so the beat counter never wraps.
    assign p_eff = (p > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : p;

    // Align entry p_eff-1 to the top cell, which feeds D_out; unused low cells load zero.
    assign aligned = d_in << (DATA_W * (DEPTH - int'(p_eff)));

    assign xfer = out_valid & out_ready;

    // Bank of DEPTH cells; each transfer moves cell k-1 into cell k, zero enters at cell 0.
    for (genvar k = 0; k < DEPTH; k++) begin : g_bank
        if (k == 0) begin : g_first
            piso_cell #(.DATA_W(DATA_W)) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .load_en  (load_bank),
                .shift_en (xfer),
                .par_in   (aligned[k*DATA_W +: DATA_W]),
                .ser_in   ({DATA_W{1'b0}}),
                .q        (cell_q[k])
            );
        end else begin : g_rest
            piso_cell #(.DATA_W(DATA_W)) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .load_en  (load_bank),
                .shift_en (xfer),
                .par_in   (aligned[k*DATA_W +: DATA_W]),
                .ser_in   (cell_q[k-1]),
                .q        (cell_q[k])
            );
        end
    end

    // Next-state, beat counter and capture strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_bank = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    load_bank = 1'b1;
                    cnt_d     = p_eff;
                    state_d   = (p_eff == '0) ? S_FIN : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (xfer) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and beats-remaining registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from state; D_out reads zero whenever no beat is offered.
    assign out_valid = (state_q == S_SHIFT);
    assign busy      = (state_q == S_SHIFT);
    assign done      = (state_q == S_FIN);
    assign D_out     = out_valid ? cell_q[DEPTH-1] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_psum_serializer.sv
// Directed bench for psum_serializer: reset, ordering, stalls, p edge cases,
// load while busy, and loopback into a serial-in/parallel-out capture model.
module tb_psum_serializer;

    localparam int DW    = 16;
    localparam int DEPTH = 24;
    localparam int CW    = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  load = 1'b0;
    logic [CW-1:0]         p_in = '0;
    logic [DEPTH*DW-1:0]   d_in = '0;
    logic                  out_ready = 1'b0;
    logic                  out_valid;
    logic [DW-1:0]         d_out;
    logic                  busy;
    logic                  done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] cap [DEPTH];

    psum_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .p         (p_in),
        .d_in      (d_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .D_out     (d_out),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- monitor: transfers, downstream capture register, done pulses ----------------
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back(d_out);
            for (int i = DEPTH - 1; i > 0; i--) cap[i] <= cap[i-1];
            cap[0] <= d_out;
        end
        if (rst_n && done) done_cnt++;
    end

    // ---------------- driver helpers ----------------
    function automatic logic [DEPTH*DW-1:0] mk(input logic [DW-1:0] base);
        logic [DEPTH*DW-1:0] r;
        for (int i = 0; i < DEPTH; i++) r[i*DW +: DW] = base + DW'(i);
        return r;
    endfunction

    // Returns #1 after the capturing edge N.
    task automatic do_load(input logic [CW-1:0] pv, input logic [DEPTH*DW-1:0] dv);
        @(posedge clk); #1;
        load = 1'b1; p_in = pv; d_in = dv;
        @(posedge clk); #1;
        load = 1'b0;
        p_in = CW'($urandom_range(0, 31));
        d_in = {12{$urandom}};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        int n;
        int dc;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || d_out !== '0) begin
            errors++;
            $display("FAIL reset_init: valid=%b busy=%b done=%b d_out=%h, required all zero",
                     out_valid, busy, done, d_out);
        end
        @(negedge clk); rst_n = 1'b1;

        // abort mid-stream after 3 beats of 8
        got_q.delete();
        out_ready = 1'b1;
        do_load(5'd8, mk(16'h8000));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        dc = done_cnt;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || d_out !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b done=%b d_out=%h, required all zero",
                     out_valid, busy, done, d_out);
        end
        checks++;
        if (got_q.size() !== 3) begin
            errors++;
            $display("FAIL reset_mid_beats: got %0d beats, required 3", got_q.size());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== dc) begin
            errors++;
            $display("FAIL reset_no_done: done pulses %0d, required %0d", done_cnt, dc);
        end

        // next load works
        got_q.delete();
        exp_q = '{16'h8101, 16'h8100};
        do_load(5'd2, mk(16'h8100));
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reset_reload_done: done=%b after %0d cycles, required 1", done, n);
        end
        checks++;
        if (got_q !== exp_q) begin
            errors++;
            $display("FAIL reset_reload_stream: got %p, required %p", got_q, exp_q);
        end
    endtask

    task automatic test_basic;
        got_q.delete();
        out_ready = 1'b1;
        do_load(5'd4, mk(16'h0A00));
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || d_out !== 16'h0A03) begin
            errors++;
            $display("FAIL basic_first: valid=%b busy=%b d_out=%h, required 1 1 0a03",
                     out_valid, busy, d_out);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || d_out !== 16'h0A03 - DW'(b) || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d: valid=%b d_out=%h done=%b, required 1 %h 0",
                         b, out_valid, d_out, done, 16'h0A03 - DW'(b));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b valid=%b, required 1 0 0",
                     done, busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: done=%b, required 0", done);
        end
    endtask

    task automatic test_stall;
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        int sent;
        got_q.delete();
        exp_q = '{16'h3002, 16'h3001, 16'h3000};
        out_ready = 1'b1;
        do_load(5'd3, mk(16'h3000));
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || d_out !== 16'h3002 - DW'(sent)) begin
                errors++;
                $display("FAIL stall_cycle%0d: valid=%b d_out=%h, required 1 %h",
                         c, out_valid, d_out, 16'h3002 - DW'(sent));
            end
            out_ready = pat[c][0];
            if (pat[c] != 0) sent++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b valid=%b, required 1 0", done, out_valid);
        end
        checks++;
        if (got_q !== exp_q) begin
            errors++;
            $display("FAIL stall_stream: got %p, required %p", got_q, exp_q);
        end
    endtask

    task automatic test_p_edges;
        int n;
        // p = 0: no beats, done for one cycle right after the capture
        got_q.delete();
        out_ready = 1'b1;
        do_load(5'd0, mk(16'h7000));
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL p0_fin: valid=%b busy=%b done=%b, required 0 0 1",
                     out_valid, busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || got_q.size() !== 0) begin
            errors++;
            $display("FAIL p0_idle: done=%b valid=%b beats=%0d, required 0 0 0",
                     done, out_valid, got_q.size());
        end

        // p = 31 clamps to 24 beats, entry 23 down to 0
        got_q.delete();
        exp_q.delete();
        for (int i = DEPTH - 1; i >= 0; i--) exp_q.push_back(16'h5100 + DW'(i));
        do_load(5'd31, mk(16'h5100));
        n = 0;
        while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL p31_done: done=%b after %0d cycles, required 1", done, n);
        end
        checks++;
        if (got_q !== exp_q) begin
            errors++;
            $display("FAIL p31_stream: got %0d beats %p, required %p", got_q.size(), got_q, exp_q);
        end
    endtask

    task automatic test_load_busy;
        int n;
        got_q.delete();
        exp_q = '{16'h6003, 16'h6002, 16'h6001, 16'h6000};
        out_ready = 1'b0;
        do_load(5'd4, mk(16'h6000));
        @(posedge clk); #1;
        load = 1'b1; p_in = 5'd2; d_in = mk(16'h9900);
        @(posedge clk); #1;
        checks++;
        if (d_out !== 16'h6003 || busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold: d_out=%h busy=%b valid=%b, required 6003 1 1",
                     d_out, busy, out_valid);
        end
        @(posedge clk); #1;
        load = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (got_q !== exp_q) begin
            errors++;
            $display("FAIL busy_stream: got %p, required %p", got_q, exp_q);
        end
    endtask

    task automatic test_loopback;
        logic [DEPTH*DW-1:0] dv;
        int n;
        int bad;
        for (int i = 0; i < DEPTH; i++) dv[i*DW +: DW] = DW'($urandom_range(0, 65535));
        out_ready = 1'b1;
        do_load(5'd24, dv);
        n = 0;
        while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (cap[i] !== dv[i*DW +: DW]) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL loopback_q%0d: got %h, required %h", i, cap[i], dv[i*DW +: DW]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_p_edges();
        test_load_busy();
        test_loopback();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
